// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU instruction sequencer and its decoder:
//   - seq_state_t : control steps IDLE, T0..T6
//   - op_class_t  : instruction class (binary, unary, wide, illegal)
//   - opcode values and instruction-register field offsets
//   - op_class()  : opcode -> class lookup
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6
  } seq_state_t;

  typedef enum logic [1:0] {
    CLS_BIN,
    CLS_UNARY,
    CLS_WIDE,
    CLS_ILLEGAL
  } op_class_t;

  localparam int OP_W    = 5;
  localparam int OP_LSB  = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  localparam logic [OP_W-1:0] OP_ADD = 5'h00;
  localparam logic [OP_W-1:0] OP_SUB = 5'h01;
  localparam logic [OP_W-1:0] OP_AND = 5'h02;
  localparam logic [OP_W-1:0] OP_OR  = 5'h03;
  localparam logic [OP_W-1:0] OP_SHR = 5'h04;
  localparam logic [OP_W-1:0] OP_SHL = 5'h05;
  localparam logic [OP_W-1:0] OP_ROR = 5'h06;
  localparam logic [OP_W-1:0] OP_ROL = 5'h07;
  localparam logic [OP_W-1:0] OP_MUL = 5'h08;
  localparam logic [OP_W-1:0] OP_DIV = 5'h09;
  localparam logic [OP_W-1:0] OP_NEG = 5'h0A;
  localparam logic [OP_W-1:0] OP_NOT = 5'h0B;

  // Anything outside the twelve defined opcodes traps as illegal.
  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_BIN;
      OP_MUL, OP_DIV:                 cls = CLS_WIDE;
      OP_NEG, OP_NOT:                 cls = CLS_UNARY;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode
//   Combinational opcode decoder, shared with the load/store sequencer.
//   Ports:
//     op_i       in  OP_W      instruction opcode field
//     op_class_o out op_class  instruction class
//     alu_op_o   out ALU_OP_W  ALU function (the opcode passed through)
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int ALU_OP_W = 5
) (
  input  logic [OP_W-1:0]     op_i,
  output op_class_t           op_class_o,
  output logic [ALU_OP_W-1:0] alu_op_o
);

  assign op_class_o = op_class(op_i);
  assign alu_op_o   = ALU_OP_W'(op_i);

endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer
//   Hardwired control-step sequencer for register ALU instructions. Walks the
//   fetch steps T0-T2 and execute steps T3-T6, producing DataPath strobes.
//   Ports:
//     clock, clear          clock (rising edge) / async active-low reset
//     start                 request one instruction (sampled in IDLE only)
//     ir_in                 IR contents from DataPath, valid from T3
//     mem_ready             memory read complete; T1 holds until it is high
//     pc_out..lo_in         1-bit DataPath control strobes
//     reg_out_en/_sel       drive general register onto the bus
//     reg_in_en/_sel        load general register from the bus
//     alu_op                ALU function while z_in is high, else 0
//     busy, done, illegal   handshake / status
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 16,
  parameter  int ALU_OP_W   = 5,
  localparam int REG_SEL_W  = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ir_in,
  input  logic                  mem_ready,
  output logic                  pc_out,
  output logic                  mar_in,
  output logic                  inc_pc,
  output logic                  pc_in,
  output logic                  md_read,
  output logic                  mdr_in,
  output logic                  mdr_out,
  output logic                  ir_in_en,
  output logic                  y_in,
  output logic                  z_in,
  output logic                  zlow_out,
  output logic                  zhigh_out,
  output logic                  hi_in,
  output logic                  lo_in,
  output logic                  reg_out_en,
  output logic                  reg_in_en,
  output logic [REG_SEL_W-1:0]  reg_out_sel,
  output logic [REG_SEL_W-1:0]  reg_in_sel,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal
);

  seq_state_t             state_q, state_d;
  logic [OP_W-1:0]        op_q;
  logic [REG_SEL_W-1:0]   ra_q, rb_q, rc_q;

  logic [OP_W-1:0]        ir_op;
  logic [REG_SEL_W-1:0]   ir_ra, ir_rb, ir_rc;
  logic [OP_W-1:0]        dec_op;
  op_class_t              dec_class;
  logic [ALU_OP_W-1:0]    dec_alu_op;

  assign ir_op = ir_in[OP_LSB +: OP_W];
  assign ir_ra = ir_in[RA_LSB +: REG_SEL_W];
  assign ir_rb = ir_in[RB_LSB +: REG_SEL_W];
  assign ir_rc = ir_in[RC_LSB +: REG_SEL_W];

  // In T3 the IR is decoded live; from T4 on the latched opcode is used, so
  // DataPath may change the IR once T3 has been left.
  assign dec_op = (state_q == S_T3) ? ir_op : op_q;

  alu_seq_decode #(
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .op_i       (dec_op),
    .op_class_o (dec_class),
    .alu_op_o   (dec_alu_op)
  );

  // rb is only ever driven during T3, straight from the IR; the latched copy
  // is kept with the other fields but has no reader here. Low IR bits are
  // outside every field.
  logic unused_bits;
  assign unused_bits = ^{ir_in[RC_LSB-1:0], rb_q};

  // Next-step selection. Only T1 can hold (waiting for memory); the execute
  // steps branch on instruction class.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = (dec_class == CLS_ILLEGAL) ? S_IDLE : S_T4;
      S_T4:   state_d = (dec_class == CLS_UNARY) ? S_IDLE : S_T5;
      S_T5:   state_d = (dec_class == CLS_WIDE) ? S_T6 : S_IDLE;
      S_T6:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Step register plus the instruction fields, captured on the edge that
  // leaves T3.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T3) begin
        op_q <= ir_op;
        ra_q <= ir_ra;
        rb_q <= ir_rb;
        rc_q <= ir_rc;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

  // Strobe decode of the current step. In T1, pc_in and zlow_out only fire in
  // the cycle that actually leaves T1 so the PC is loaded exactly once.
  always_comb begin
    pc_out      = 1'b0;
    mar_in      = 1'b0;
    inc_pc      = 1'b0;
    pc_in       = 1'b0;
    md_read     = 1'b0;
    mdr_in      = 1'b0;
    mdr_out     = 1'b0;
    ir_in_en    = 1'b0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    zlow_out    = 1'b0;
    zhigh_out   = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    reg_out_en  = 1'b0;
    reg_in_en   = 1'b0;
    reg_out_sel = '0;
    reg_in_sel  = '0;
    alu_op      = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        md_read  = 1'b1;
        mdr_in   = 1'b1;
        pc_in    = mem_ready;
        zlow_out = mem_ready;
      end
      S_T2: begin
        mdr_out  = 1'b1;
        ir_in_en = 1'b1;
      end
      S_T3: begin
        case (dec_class)
          CLS_BIN, CLS_WIDE: begin
            reg_out_en  = 1'b1;
            reg_out_sel = ir_rb;
            y_in        = 1'b1;
          end
          CLS_UNARY: begin
            reg_out_en  = 1'b1;
            reg_out_sel = ir_rb;
            alu_op      = dec_alu_op;
            z_in        = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_T4: begin
        if (dec_class == CLS_UNARY) begin
          zlow_out   = 1'b1;
          reg_in_en  = 1'b1;
          reg_in_sel = ra_q;
          done       = 1'b1;
        end else begin
          reg_out_en  = 1'b1;
          reg_out_sel = rc_q;
          alu_op      = dec_alu_op;
          z_in        = 1'b1;
        end
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (dec_class == CLS_WIDE) begin
          lo_in = 1'b1;
        end else begin
          reg_in_en  = 1'b1;
          reg_in_sel = ra_q;
          done       = 1'b1;
        end
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
